// File: rtl/pkg_varianceNorm.sv
// Shared types and constants for the variance / normalisation calculator.
//   STATES_t      : FSM encoding of variance_norm_calc
//   CORNER_A..D   : window-corner cache addresses
//   INT_W, SQ_W, WIN_W, VAR_W, SQRT_ITERS : default widths
package pkg_varianceNorm;
  localparam int INT_W      = 32;
  localparam int SQ_W       = 48;
  localparam int WIN_W      = 8;
  localparam int VAR_W      = 64;
  localparam int SQRT_ITERS = VAR_W / 2;

  localparam logic [1:0] CORNER_A = 2'd0;  // top-left
  localparam logic [1:0] CORNER_B = 2'd1;  // top-right
  localparam logic [1:0] CORNER_C = 2'd2;  // bottom-left
  localparam logic [1:0] CORNER_D = 2'd3;  // bottom-right

  typedef enum logic [2:0] {
    S_Ready, S_Load, S_Sum, S_Mul, S_Var, S_Sqrt, S_Done
  } STATES_t;
endpackage

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root, one root bit per cycle, MSB first.
// Takes exactly VAR_W/2 cycles after load.
//   clk, rst : clock, async active-high reset
//   load     : capture din and start (overrides any run in progress)
//   din      : radicand, VAR_W bits
//   busy     : iterating
//   done     : final iteration in progress this cycle
//   root     : value the root register takes at the next edge; the finished
//              root while done is high
module isqrt_seq #(
  parameter int VAR_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [VAR_W-1:0]   din,
  output logic               busy,
  output logic               done,
  output logic [VAR_W/2-1:0] root
);
  localparam int H  = VAR_W / 2;
  localparam int CW = $clog2(H);

  logic [VAR_W-1:0] op;
  logic [H-1:0]     rem, rt, rem_nxt, rt_nxt;
  logic [H+1:0]     rem_t, trial;
  logic [CW-1:0]    cnt;
  logic             ge;

  // The remainder stays below 2^H until the last iteration, so H bits are
  // enough to carry it; the final remainder is never used.
  always_comb begin
    rem_t   = {rem, op[VAR_W-1 -: 2]};
    trial   = {rt, 2'b01};
    ge      = (rem_t >= trial);
    rem_nxt = ge ? H'(rem_t - trial) : rem_t[H-1:0];
    rt_nxt  = {rt[H-2:0], ge};
  end

  assign done = busy && (cnt == CW'(H - 1));
  assign root = rt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op   <= '0;
      rem  <= '0;
      rt   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      op   <= din;
      rem  <= '0;
      rt   <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      op   <= op << 2;
      rem  <= rem_nxt;
      rt   <= rt_nxt;
      cnt  <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/variance_norm_calc.sv
// Per-core window variance / normalisation factor.
// Double-buffered 4-corner cache (integral + squared integral) filled from the
// variance loader; on start computes variance = area*sqsum - sum^2 and
// stddev = max(1, isqrt(variance)).
//   clk, reset                  : clock, async active-high reset
//   vcw_we/waddr/wdata          : integral corner write into bank vcw_dblBuf
//   vcw_weSQ/waddrSQ/wdataSQ    : squared corner write into bank vcw_dblBuf
//   start, rd_bank, win_size    : launch (sampled only while ready)
//   ack                         : release done
//   ready, done                 : FSM status
//   variance, stddev            : results, valid while done
module variance_norm_calc #(
  parameter int INT_W = pkg_varianceNorm::INT_W,
  parameter int SQ_W  = pkg_varianceNorm::SQ_W,
  parameter int WIN_W = pkg_varianceNorm::WIN_W,
  parameter int VAR_W = pkg_varianceNorm::VAR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vcw_we,
  input  logic [1:0]         vcw_waddr,
  input  logic [INT_W-1:0]   vcw_wdata,
  input  logic               vcw_weSQ,
  input  logic [1:0]         vcw_waddrSQ,
  input  logic [SQ_W-1:0]    vcw_wdataSQ,
  input  logic               vcw_dblBuf,
  input  logic               start,
  input  logic               rd_bank,
  input  logic [WIN_W-1:0]   win_size,
  input  logic               ack,
  output logic               ready,
  output logic               done,
  output logic [VAR_W-1:0]   variance,
  output logic [VAR_W/2-1:0] stddev
);
  import pkg_varianceNorm::*;

  STATES_t state, state_nxt;

  logic [1:0][3:0][INT_W-1:0] c_int;
  logic [1:0][3:0][SQ_W-1:0]  c_sq;

  logic                 rd_bank_q;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [2*WIN_W-1:0]   win_dx, area;
  logic [INT_W-1:0]     ca, cb, cc, cd, sum;
  logic [SQ_W-1:0]      sa, sb, sc, sd, sqsum;
  logic [VAR_W-1:0]     p, q, var_nxt;
  logic                 sq_busy, sq_done;
  logic [VAR_W/2-1:0]   sq_root;

  // Cache writes are independent of the FSM; corners are copied out in
  // S_Load, so later writes never disturb a run in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_int <= '0;
      c_sq  <= '0;
    end else begin
      if (vcw_we)   c_int[vcw_dblBuf][vcw_waddr]   <= vcw_wdata;
      if (vcw_weSQ) c_sq[vcw_dblBuf][vcw_waddrSQ]  <= vcw_wdataSQ;
    end
  end

  // Undersized windows wrap here by design; the caller guarantees win_size>=2.
  assign win_d   = win_q - WIN_W'(2);
  assign win_dx  = {{WIN_W{1'b0}}, win_d};
  assign var_nxt = (p < q) ? '0 : p - q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_bank_q <= 1'b0;
      win_q     <= '0;
      area      <= '0;
      {ca, cb, cc, cd} <= '0;
      {sa, sb, sc, sd} <= '0;
      sum       <= '0;
      sqsum     <= '0;
      p         <= '0;
      q         <= '0;
      variance  <= '0;
      stddev    <= '0;
    end else begin
      case (state)
        S_Ready: if (start) begin
          rd_bank_q <= rd_bank;
          win_q     <= win_size;
        end
        S_Load: begin
          ca   <= c_int[rd_bank_q][CORNER_A];
          cb   <= c_int[rd_bank_q][CORNER_B];
          cc   <= c_int[rd_bank_q][CORNER_C];
          cd   <= c_int[rd_bank_q][CORNER_D];
          sa   <= c_sq[rd_bank_q][CORNER_A];
          sb   <= c_sq[rd_bank_q][CORNER_B];
          sc   <= c_sq[rd_bank_q][CORNER_C];
          sd   <= c_sq[rd_bank_q][CORNER_D];
          area <= win_dx * win_dx;
        end
        S_Sum: begin
          // Modular wrap gives the true window sum for integral images.
          sum   <= ca - cb - cc + cd;
          sqsum <= sa - sb - sc + sd;
        end
        S_Mul: begin
          p <= VAR_W'(area) * VAR_W'(sqsum);
          q <= VAR_W'(sum) * VAR_W'(sum);
        end
        S_Var: variance <= var_nxt;
        S_Sqrt: if (sq_done)
          stddev <= (sq_root == '0) ? {{(VAR_W/2-1){1'b0}}, 1'b1} : sq_root;
        default: ;
      endcase
    end
  end

  isqrt_seq #(.VAR_W(VAR_W)) u_isqrt (
    .clk  (clk),
    .rst  (reset),
    .load (state == S_Var),
    .din  (var_nxt),
    .busy (sq_busy),
    .done (sq_done),
    .root (sq_root)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_Ready;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_Ready: if (start) state_nxt = S_Load;
      S_Load:  state_nxt = S_Sum;
      S_Sum:   state_nxt = S_Mul;
      S_Mul:   state_nxt = S_Var;
      S_Var:   state_nxt = S_Sqrt;
      S_Sqrt:  if (sq_busy && sq_done) state_nxt = S_Done;
      S_Done:  if (ack) state_nxt = S_Ready;
      default: state_nxt = S_Ready;
    endcase
  end

  always_comb begin
    ready = (state == S_Ready);
    done  = (state == S_Done);
  end
endmodule

// File: tb/tb_variance_norm_calc.sv
module tb_variance_norm_calc;
  logic        clk = 1'b0;
  logic        reset;
  logic        vcw_we, vcw_weSQ, vcw_dblBuf;
  logic [1:0]  vcw_waddr, vcw_waddrSQ;
  logic [31:0] vcw_wdata;
  logic [47:0] vcw_wdataSQ;
  logic        start, rd_bank, ack;
  logic [7:0]  win_size;
  logic        ready, done;
  logic [63:0] variance;
  logic [31:0] stddev;

  int checks = 0;
  int failures = 0;

  variance_norm_calc dut (
    .clk(clk), .reset(reset),
    .vcw_we(vcw_we), .vcw_waddr(vcw_waddr), .vcw_wdata(vcw_wdata),
    .vcw_weSQ(vcw_weSQ), .vcw_waddrSQ(vcw_waddrSQ), .vcw_wdataSQ(vcw_wdataSQ),
    .vcw_dblBuf(vcw_dblBuf), .start(start), .rd_bank(rd_bank), .win_size(win_size),
    .ack(ack), .ready(ready), .done(done), .variance(variance), .stddev(stddev)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic bank, input logic [1:0] a, input logic [31:0] d,
                    input logic [47:0] dsq);
    vcw_we = 1; vcw_weSQ = 1; vcw_dblBuf = bank;
    vcw_waddr = a; vcw_waddrSQ = a; vcw_wdata = d; vcw_wdataSQ = dsq;
    @(posedge clk); #1;
    vcw_we = 0; vcw_weSQ = 0;
  endtask

  task automatic load_bank(input logic bank, input logic [31:0] a, b, c, d,
                           input logic [47:0] sa, sb, sc, sd);
    wr(bank, 2'd0, a, sa);
    wr(bank, 2'd1, b, sb);
    wr(bank, 2'd2, c, sc);
    wr(bank, 2'd3, d, sd);
  endtask

  // lat = number of edges after the start-sampling edge until done is seen
  task automatic run(input logic bank, input logic [7:0] win, output int lat);
    start = 1; rd_bank = bank; win_size = win;
    @(posedge clk); #1;
    start = 0; lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic do_ack();
    ack = 1;
    @(posedge clk); #1;
    ack = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL reset_status ready=%b done=%b want ready=1 done=0", ready, done);
    end
    checks++;
    if (variance !== 64'd0 || stddev !== 32'd0) begin
      failures++; $display("FAIL reset_outputs var=%0d sd=%0d want 0 0", variance, stddev);
    end
  endtask

  task automatic test_uniform();
    int lat;
    load_bank(0, 0, 0, 0, 4840, 0, 0, 0, 48400);
    run(0, 8'd24, lat);
    checks++;
    if (lat !== 36) begin failures++; $display("FAIL uniform_latency got=%0d want=36", lat); end
    checks++;
    if (variance !== 64'd0 || stddev !== 32'd1) begin
      failures++; $display("FAIL uniform_result var=%0d sd=%0d want 0 1", variance, stddev);
    end
    do_ack();
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL uniform_ack ready=%b done=%b want 1 0", ready, done);
    end
  endtask

  task automatic test_half();
    int lat;
    wr(0, 2'd3, 4840, 96800);
    run(0, 8'd24, lat);
    checks++;
    if (lat !== 36 || variance !== 64'd23425600 || stddev !== 32'd4840) begin
      failures++;
      $display("FAIL half lat=%0d var=%0d sd=%0d want 36 23425600 4840", lat, variance, stddev);
    end
    do_ack();
  endtask

  // Wrapped corners: sqD chosen so the wrapped sqsum is 96800 as in test_half.
  task automatic test_wrap();
    int lat;
    load_bank(0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h0000_12D8,
              48'hFFFF_FFFF_FFF0, 48'hFFFF_FFFF_FFF0, 48'hFFFF_FFFF_FFF0, 48'd96784);
    run(0, 8'd24, lat);
    checks++;
    if (lat !== 36 || variance !== 64'd23425600 || stddev !== 32'd4840) begin
      failures++;
      $display("FAIL wrap lat=%0d var=%0d sd=%0d want 36 23425600 4840", lat, variance, stddev);
    end
    do_ack();
  endtask

  task automatic test_dbl_buf();
    int n, lat;
    start = 1; rd_bank = 0; win_size = 8'd24;
    @(posedge clk); #1;
    start = 0; n = 0;
    // S_Load cycle: overwrite the corner being read; the old value must be used
    vcw_we = 1; vcw_weSQ = 1; vcw_dblBuf = 0;
    vcw_waddr = 2'd3; vcw_waddrSQ = 2'd3; vcw_wdata = 32'd7; vcw_wdataSQ = 48'd5;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        vcw_waddr = 2'd0; vcw_waddrSQ = 2'd0; vcw_wdata = 32'd99; vcw_wdataSQ = 48'd99;
      end else begin
        vcw_dblBuf = 1; vcw_waddr = 2'(n); vcw_waddrSQ = 2'(n);
        vcw_wdata = 32'hFFFF; vcw_wdataSQ = 48'hFFFF;
      end
    end
    vcw_we = 0; vcw_weSQ = 0;
    checks++;
    if (n !== 36 || variance !== 64'd23425600 || stddev !== 32'd4840) begin
      failures++;
      $display("FAIL dblbuf_bank0 lat=%0d var=%0d sd=%0d want 36 23425600 4840", n, variance, stddev);
    end
    do_ack();
    // bank1 now A=B=C=0xFFFF; lift D so bank1 yields sum 4840 / sqsum 96800
    wr(1, 2'd3, 32'hFFFF + 32'd4840, 48'hFFFF + 48'd96800);
    run(1, 8'd24, lat);
    checks++;
    if (lat !== 36 || variance !== 64'd23425600 || stddev !== 32'd4840) begin
      failures++;
      $display("FAIL dblbuf_bank1 lat=%0d var=%0d sd=%0d want 36 23425600 4840", lat, variance, stddev);
    end
    do_ack();
  endtask

  // win_size below 2 wraps: 1 -> 255^2, 0 -> 254^2; sqsum=1, sum=0
  task automatic test_small_win();
    int lat;
    load_bank(0, 0, 0, 0, 0, 0, 0, 0, 1);
    run(0, 8'd1, lat);
    checks++;
    if (variance !== 64'd65025 || stddev !== 32'd255) begin
      failures++; $display("FAIL win1 var=%0d sd=%0d want 65025 255", variance, stddev);
    end
    do_ack();
    run(0, 8'd0, lat);
    checks++;
    if (variance !== 64'd64516 || stddev !== 32'd254) begin
      failures++; $display("FAIL win0 var=%0d sd=%0d want 64516 254", variance, stddev);
    end
    do_ack();
  endtask

  task automatic test_handshake();
    int n, bad;
    load_bank(0, 0, 0, 0, 4840, 0, 0, 0, 96800);
    start = 1; rd_bank = 0; win_size = 8'd24;
    @(posedge clk); #1;
    start = 0; n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
      // stray start mid-S_Sqrt with different operands
      if (n == 20) begin start = 1; rd_bank = 1; win_size = 8'd3; end
      else start = 0;
    end
    checks++;
    if (n !== 36 || variance !== 64'd23425600 || stddev !== 32'd4840) begin
      failures++;
      $display("FAIL stray_start lat=%0d var=%0d sd=%0d want 36 23425600 4840", n, variance, stddev);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b1 || ready !== 1'b0 || variance !== 64'd23425600 || stddev !== 32'd4840)
        bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL hold_done unstable_cycles=%0d want 0", bad); end
    ack = 1; start = 1; rd_bank = 0;
    @(posedge clk); #1;
    ack = 0; start = 0;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL ack_with_start ready=%b done=%b want 1 0", ready, done);
    end
  endtask

  task automatic test_reset_mid();
    int lat, seen;
    start = 1; rd_bank = 0; win_size = 8'd24;
    @(posedge clk); #1;
    start = 0;
    repeat (20) @(posedge clk);
    #1 reset = 1;
    #1;
    checks++;
    if (done !== 1'b0 || variance !== 64'd0 || stddev !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs done=%b var=%0d sd=%0d want 0 0 0", done, variance, stddev);
    end
    @(posedge clk); #1 reset = 0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0 || ready !== 1'b1) begin
      failures++; $display("FAIL reset_mid_no_done done_cycles=%0d ready=%b want 0 1", seen, ready);
    end
    run(0, 8'd24, lat);
    checks++;
    if (lat !== 36 || variance !== 64'd0 || stddev !== 32'd1) begin
      failures++;
      $display("FAIL reset_cache_cleared lat=%0d var=%0d sd=%0d want 36 0 1", lat, variance, stddev);
    end
    do_ack();
    load_bank(0, 0, 0, 0, 4840, 0, 0, 0, 96800);
    run(0, 8'd24, lat);
    checks++;
    if (lat !== 36 || variance !== 64'd23425600 || stddev !== 32'd4840) begin
      failures++;
      $display("FAIL after_reset lat=%0d var=%0d sd=%0d want 36 23425600 4840", lat, variance, stddev);
    end
    do_ack();
  endtask

  initial begin
    reset = 1; vcw_we = 0; vcw_weSQ = 0; vcw_dblBuf = 0;
    vcw_waddr = 0; vcw_waddrSQ = 0; vcw_wdata = 0; vcw_wdataSQ = 0;
    start = 0; rd_bank = 0; win_size = 0; ack = 0;
    test_reset();
    test_uniform();
    test_half();
    test_wrap();
    test_dbl_buf();
    test_small_win();
    test_handshake();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
